// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline definitions: ALU classes, opcodes and the decoder control bundle.
package cpu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef struct packed {
    logic       reg_write;
    logic       memto_reg;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // R-type, beq and sw all read rt as a source register
  function automatic logic uses_rt(input logic alu_src, input logic mem_write);
    return ~alu_src | mem_write;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decoder controls, operands and addresses in, registered copies out.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              stall_i, flush_i;
  logic              RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i;
  logic [1:0]        ALUOp_i;
  logic [DATA_W-1:0] RSdata_i, RTdata_i, Imm_i;
  logic [5:0]        funct_i;
  logic [REG_AW-1:0] RSaddr_i, RTaddr_i, RDaddr_i;

  logic              RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RegDst_o, ALUSrc_o;
  logic [1:0]        ALUOp_o;
  logic [DATA_W-1:0] RSdata_o, RTdata_o, Imm_o;
  logic [5:0]        funct_o;
  logic [REG_AW-1:0] RSaddr_o, RTaddr_o, RDaddr_o;
  logic              valid_o, hazard_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, flush_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i,
           ALUOp_i, RSdata_i, RTdata_i, Imm_i, funct_i, RSaddr_i, RTaddr_i, RDaddr_i,
    input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RegDst_o, ALUSrc_o, ALUOp_o,
           RSdata_o, RTdata_o, Imm_o, funct_o, RSaddr_o, RTaddr_o, RDaddr_o,
           valid_o, hazard_o, bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, RegDst_i, ALUSrc_i,
           ALUOp_i, RSdata_i, RTdata_i, Imm_i, funct_i, RSaddr_i, RTaddr_i, RDaddr_i,
    output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, RegDst_o, ALUSrc_o, ALUOp_o,
           RSdata_o, RTdata_o, Imm_o, funct_o, RSaddr_o, RTaddr_o, RDaddr_o,
           valid_o, hazard_o, bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: a valid load in EX whose destination is read by the instruction in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  output logic              hazard_o
);
  // $0 never carries a dependency
  assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) &
                    ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and downstream hold.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);
  typedef struct packed {
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
  } ops_t;

  ctrl_t ctrl_in, ctrl_d, ctrl_q;
  ops_t  ops_in, ops_d, ops_q;
  logic  valid_d, valid_q;
  logic  hazard;

  assign ctrl_in = {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
                    bus.RegDst_i, bus.ALUSrc_i, bus.ALUOp_i};
  assign ops_in  = {bus.RSdata_i, bus.RTdata_i, bus.Imm_i, bus.funct_i,
                    bus.RSaddr_i, bus.RTaddr_i, bus.RDaddr_i};

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (ops_q.rt_addr),
    .id_rs_i       (bus.RSaddr_i),
    .id_rt_i       (bus.RTaddr_i),
    .id_uses_rt_i  (uses_rt(bus.ALUSrc_i, bus.MemWrite_i)),
    .hazard_o      (hazard)
  );

  // Bubbles clear only controls and valid; operand fields keep their last values
  always_comb begin
    ctrl_d  = ctrl_q;
    ops_d   = ops_q;
    valid_d = valid_q;
    if (bus.flush_i || (!bus.stall_i && hazard)) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
    end else if (!bus.stall_i) begin
      ctrl_d  = ctrl_in;
      ops_d   = ops_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q  <= '0;
      ops_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      ops_q   <= ops_d;
      valid_q <= valid_d;
    end
  end

  assign bus.RegWrite_o = ctrl_q.reg_write;
  assign bus.MemtoReg_o = ctrl_q.memto_reg;
  assign bus.MemRead_o  = ctrl_q.mem_read;
  assign bus.MemWrite_o = ctrl_q.mem_write;
  assign bus.RegDst_o   = ctrl_q.reg_dst;
  assign bus.ALUSrc_o   = ctrl_q.alu_src;
  assign bus.ALUOp_o    = ctrl_q.alu_op;
  assign bus.RSdata_o   = ops_q.rs_data;
  assign bus.RTdata_o   = ops_q.rt_data;
  assign bus.Imm_o      = ops_q.imm;
  assign bus.funct_o    = ops_q.funct;
  assign bus.RSaddr_o   = ops_q.rs_addr;
  assign bus.RTaddr_o   = ops_q.rt_addr;
  assign bus.RDaddr_o   = ops_q.rd_addr;
  assign bus.valid_o    = valid_q;
  assign bus.hazard_o   = hazard;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             bubble;

  always_comb begin
    bubble = bus.flush_i | (~bus.stall_i & hazard);
    cnt_d  = cnt_q;
    if (bubble && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.bubble_cnt_o = cnt_q;
`else
  assign bus.bubble_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against an instruction-level model.
module tb_id_ex_stage;
  import cpu_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  bus2 ();

  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(16)) dut  (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(2))  dut2 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus2));

  assign bus2.stall_i    = bus.stall_i;
  assign bus2.flush_i    = bus.flush_i;
  assign bus2.RegWrite_i = bus.RegWrite_i;
  assign bus2.MemtoReg_i = bus.MemtoReg_i;
  assign bus2.MemRead_i  = bus.MemRead_i;
  assign bus2.MemWrite_i = bus.MemWrite_i;
  assign bus2.RegDst_i   = bus.RegDst_i;
  assign bus2.ALUSrc_i   = bus.ALUSrc_i;
  assign bus2.ALUOp_i    = bus.ALUOp_i;
  assign bus2.RSdata_i   = bus.RSdata_i;
  assign bus2.RTdata_i   = bus.RTdata_i;
  assign bus2.Imm_i      = bus.Imm_i;
  assign bus2.funct_i    = bus.funct_i;
  assign bus2.RSaddr_i   = bus.RSaddr_i;
  assign bus2.RTaddr_i   = bus.RTaddr_i;
  assign bus2.RDaddr_i   = bus.RDaddr_i;

  // One instruction as seen by the model: controls, operands, addresses, valid
  typedef struct {
    logic        rw, m2r, mr, mw, rd, as;
    logic [1:0]  op;
    logic [31:0] rs, rt, imm;
    logic [5:0]  f;
    logic [4:0]  rsa, rta, rda;
    logic        v;
  } instr_t;

  instr_t id, ex;
  logic   stall = 1'b0, flush = 1'b0;
  int     cnt16 = 0, cnt2 = 0;
  int     n_asrt = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.stall_i = stall;        bus.flush_i = flush;
    bus.RegWrite_i = id.rw;     bus.MemtoReg_i = id.m2r;  bus.MemRead_i = id.mr;
    bus.MemWrite_i = id.mw;     bus.RegDst_i = id.rd;     bus.ALUSrc_i = id.as;
    bus.ALUOp_i = id.op;        bus.RSdata_i = id.rs;     bus.RTdata_i = id.rt;
    bus.Imm_i = id.imm;         bus.funct_i = id.f;
    bus.RSaddr_i = id.rsa;      bus.RTaddr_i = id.rta;    bus.RDaddr_i = id.rda;
  endtask

  // A load in EX blocks any ID instruction that reads its destination
  function automatic logic m_haz();
    logic reads_rt;
    reads_rt = !id.as || id.mw;
    return ex.v && ex.mr && ex.rta != 5'd0 &&
           (ex.rta == id.rsa || (reads_rt && ex.rta == id.rta));
  endfunction

  task automatic m_edge();
    logic h;
    h = m_haz();
    if (flush || (!stall && h)) begin
      {ex.rw, ex.m2r, ex.mr, ex.mw, ex.rd, ex.as, ex.op, ex.v} = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
`endif
    end else if (!stall) begin
      ex = id;
      ex.v = 1'b1;
    end
  endtask

  task automatic m_reset();
    ex = '{default: '0};
    cnt16 = 0;
    cnt2 = 0;
  endtask

  task automatic check_out(input string pfx);
    chk({pfx, "_ctrl"}, {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                         bus.RegDst_o, bus.ALUSrc_o, bus.ALUOp_o},
                        {ex.rw, ex.m2r, ex.mr, ex.mw, ex.rd, ex.as, ex.op});
    chk({pfx, "_data"}, {bus.RSdata_o, bus.RTdata_o, bus.Imm_o}, {ex.rs, ex.rt, ex.imm});
    chk({pfx, "_addr"}, {bus.funct_o, bus.RSaddr_o, bus.RTaddr_o, bus.RDaddr_o},
                        {ex.f, ex.rsa, ex.rta, ex.rda});
    chk({pfx, "_valid"}, bus.valid_o, ex.v);
    chk({pfx, "_cnt"}, bus.bubble_cnt_o, cnt16[15:0]);
    chk({pfx, "_cnt_sat"}, bus2.bubble_cnt_o, cnt2[1:0]);
  endtask

  // Starts and ends just after a falling edge
  task automatic cycle(input string pfx);
    apply();
    #1 chk({pfx, "_hazard"}, bus.hazard_o, m_haz());
    @(posedge clk_i);
    m_edge();
    #1 check_out(pfx);
    @(negedge clk_i);
  endtask

  task automatic set_i(input logic rw, m2r, mr, mw, rd, as, input logic [1:0] op,
                       input logic [4:0] rsa, rta, rda, input logic [31:0] imm);
    id.rw = rw; id.m2r = m2r; id.mr = mr; id.mw = mw; id.rd = rd; id.as = as; id.op = op;
    id.rsa = rsa; id.rta = rta; id.rda = rda; id.imm = imm;
    id.rs = $urandom; id.rt = $urandom; id.f = 6'($urandom_range(0, 63));
    id.v = 1'b0;
  endtask

  task automatic async_reset(input string pfx);
    #2 rst_i = 1'b0;
    m_reset();
    #1 check_out(pfx);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    id = '{default: '0};
    m_reset();
    apply();

    // Reset held across edges, then release
    @(posedge clk_i);
    #1 check_out("rst");
    @(negedge clk_i);
    rst_i = 1'b1;
    cycle("idle");

    // addi $5,$1,5
    set_i(1, 0, 0, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd5, 5'd0, 32'h5);
    cycle("addi");
    chk("addi_imm", bus.Imm_o, 32'h5);

    // lw $2 then add $3,$2,$4: one bubble, then the add loads
    set_i(1, 1, 1, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd2, 5'd0, 32'h4);
    cycle("lw2");
    set_i(1, 0, 0, 0, 1, 0, ALUOP_RTYPE, 5'd2, 5'd4, 5'd3, 32'h0);
    apply();
    #1 chk("lu_haz", bus.hazard_o, 1'b1);
    cycle("lu_bub");
    chk("lu_bub_valid", bus.valid_o, 1'b0);
    cycle("lu_add");
    chk("lu_add_valid", bus.valid_o, 1'b1);

    // lw $0 then reader of $0: no hazard
    set_i(1, 1, 1, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd0, 5'd0, 32'h8);
    cycle("lw0");
    set_i(1, 0, 0, 0, 1, 0, ALUOP_RTYPE, 5'd0, 5'd0, 5'd7, 32'h0);
    apply();
    #1 chk("lw0_nohaz", bus.hazard_o, 1'b0);
    cycle("lw0_use");

    // lw $2 then addi $5,$6,1: rt is a destination, not a source
    set_i(1, 1, 1, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd2, 5'd0, 32'h0);
    cycle("lw2b");
    set_i(1, 0, 0, 0, 0, 1, ALUOP_ADD, 5'd6, 5'd5, 5'd0, 32'h1);
    apply();
    #1 chk("addi_nohaz", bus.hazard_o, 1'b0);
    cycle("addi_use");

    // Stall alone holds for 3 cycles even with new ID inputs
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_i(1, 0, 1, 1, 1, 0, ALUOP_SUB, 5'd9, 5'd10, 5'd11, 32'hdead);
      cycle("stall");
    end
    chk("stall_imm", bus.Imm_o, 32'h1);
    // Flush wins over stall
    flush = 1'b1;
    cycle("stall_flush");
    stall = 1'b0;
    flush = 1'b0;

    // Counter: 3 flushes + 1 hazard, then one more flush to saturate the 2-bit copy
    async_reset("rst2");
    flush = 1'b1;
    for (int i = 0; i < 3; i++) cycle("cnt_flush");
    flush = 1'b0;
    set_i(1, 1, 1, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd3, 5'd0, 32'h0);
    cycle("cnt_lw");
    set_i(1, 0, 0, 1, 0, 1, ALUOP_ADD, 5'd1, 5'd3, 5'd0, 32'h0);
    cycle("cnt_sw_haz");
`ifdef ID_EX_BUBBLE_CNT_EN
    chk("cnt_four", bus.bubble_cnt_o, 16'd4);
`else
    chk("cnt_off", bus.bubble_cnt_o, 16'd0);
`endif
    flush = 1'b1;
    cycle("cnt_fifth");
    flush = 1'b0;

    // Random traffic over a small register set so loads and uses collide often
    for (int i = 0; i < 400; i++) begin
      set_i(1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle("rnd");
    end

    // Reset in the middle of a stall, then the first edge loads normally
    set_i(1, 1, 1, 0, 0, 1, ALUOP_ADD, 5'd1, 5'd2, 5'd0, 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    cycle("pre_lw");
    stall = 1'b1;
    set_i(1, 0, 0, 0, 1, 0, ALUOP_RTYPE, 5'd2, 5'd2, 5'd4, 32'h0);
    cycle("mid_stall");
    apply();
    async_reset("rst_mid");
    stall = 1'b0;
    cycle("post_rst");
    chk("post_rst_valid", bus.valid_o, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
